// File: rtl/if_id_stage_if.sv
// IF/ID boundary bundle: fetch-side inputs, EX-side hazard/branch feedback,
// and the registered ID-side outputs plus PC/bubble control.
interface if_id_stage_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] Instruction_IF;
    logic [DATA_W-1:0] PCNow_IF;
    logic [DATA_W-1:0] PCNext4_IF;
    logic              MemRead_EX;
    logic [4:0]        WriteReg_EX;
    logic              BranchTaken_EX;
    logic [DATA_W-1:0] Instruction_ID;
    logic [DATA_W-1:0] PCNow_ID;
    logic [DATA_W-1:0] PCNext4_ID;
    logic              Valid_ID;
    logic              PCWrite;
    logic              Bubble_ID;
    logic [15:0]       StallCount;

    modport master (
        output Instruction_IF, PCNow_IF, PCNext4_IF,
        output MemRead_EX, WriteReg_EX, BranchTaken_EX,
        input  Instruction_ID, PCNow_ID, PCNext4_ID, Valid_ID,
        input  PCWrite, Bubble_ID, StallCount
    );

    modport slave (
        input  Instruction_IF, PCNow_IF, PCNext4_IF,
        input  MemRead_EX, WriteReg_EX, BranchTaken_EX,
        output Instruction_ID, PCNow_ID, PCNext4_ID, Valid_ID,
        output PCWrite, Bubble_ID, StallCount
    );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use stall detection, branch flush and a
// saturating stall-cycle counter, sequenced by a RUN/STALL/FLUSH FSM.
module if_id_stage (
    input logic          clk,
    input logic          rst,
    if_id_stage_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} state_t;

    state_t      state;
    state_t      stateNext;
    logic        hazard;
    logic        loadEn;
    logic        flushEn;
    logic        countEn;
    logic        pcWrite;
    logic        bubble;
    logic [31:0] instrId;
    logic [31:0] pcNowId;
    logic [31:0] pcNext4Id;
    logic        validId;
    logic [15:0] stallCnt;

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign hazard = validId & bus.MemRead_EX & (bus.WriteReg_EX != 5'd0) &
                    ((bus.WriteReg_EX == instrId[25:21]) |
                     (bus.WriteReg_EX == instrId[20:16]));

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            RUN, STALL: begin
                if (bus.BranchTaken_EX) stateNext = FLUSH;
                else if (hazard)        stateNext = STALL;
                else                    stateNext = RUN;
            end
            FLUSH: begin
                if (bus.BranchTaken_EX) stateNext = FLUSH;
                else                    stateNext = RUN;
            end
            default: stateNext = RUN;
        endcase
    end

    // Branch outranks hazard everywhere; reset forces a frozen, bubbled stage.
    always_comb begin
        pcWrite = 1'b0;
        bubble  = 1'b1;
        loadEn  = 1'b0;
        flushEn = 1'b0;
        countEn = 1'b0;
        if (!rst) begin
            case (state)
                RUN, STALL: begin
                    if (bus.BranchTaken_EX) begin
                        flushEn = 1'b1;
                        pcWrite = 1'b1;
                    end else if (hazard) begin
                        countEn = 1'b1;
                    end else begin
                        loadEn  = 1'b1;
                        pcWrite = 1'b1;
                        bubble  = 1'b0;
                    end
                end
                FLUSH: begin
                    if (bus.BranchTaken_EX) begin
                        flushEn = 1'b1;
                        pcWrite = 1'b1;
                    end else begin
                        loadEn  = 1'b1;
                        pcWrite = 1'b1;
                        bubble  = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flushEn) begin
            instrId   <= '0;
            pcNowId   <= '0;
            pcNext4Id <= '0;
            validId   <= 1'b0;
        end else if (loadEn) begin
            instrId   <= bus.Instruction_IF;
            pcNowId   <= bus.PCNow_IF;
            pcNext4Id <= bus.PCNext4_IF;
            validId   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)          stallCnt <= '0;
        else if (countEn) stallCnt <= satInc(stallCnt);
    end

    assign bus.Instruction_ID = instrId;
    assign bus.PCNow_ID       = pcNowId;
    assign bus.PCNext4_ID     = pcNext4Id;
    assign bus.Valid_ID       = validId;
    assign bus.PCWrite        = pcWrite;
    assign bus.Bubble_ID      = bubble;
    assign bus.StallCount     = stallCnt;
endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: reset, load-use stall, branch flush,
// branch/hazard priority, register-0 immunity, counter saturation, mid-stall reset.
module tb_if_id_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nChecks = 0;
    int   nFails  = 0;

    if_id_stage_if bus();

    if_id_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic mr, input logic [4:0] wr, input logic br);
        @(negedge clk);
        bus.Instruction_IF = instr;
        bus.PCNow_IF       = pc;
        bus.PCNext4_IF     = pc + 32'd4;
        bus.MemRead_EX     = mr;
        bus.WriteReg_EX    = wr;
        bus.BranchTaken_EX = br;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive($urandom, $urandom, 1'b1, 5'($urandom), 1'b1);
        #1;
        nChecks++;
        if (bus.PCWrite !== 1'b0 || bus.Bubble_ID !== 1'b1) begin
            nFails++;
            $display("FAIL reset_ctrl: PCWrite=%b Bubble=%b, want 0 1", bus.PCWrite, bus.Bubble_ID);
        end
        tick();
        drive($urandom, $urandom, 1'b0, 5'($urandom), 1'b1);
        tick();
        nChecks++;
        if (bus.Instruction_ID !== 32'h0 || bus.PCNow_ID !== 32'h0 || bus.PCNext4_ID !== 32'h0 ||
            bus.Valid_ID !== 1'b0 || bus.StallCount !== 16'h0) begin
            nFails++;
            $display("FAIL reset_regs: instr=%h pc=%h pc4=%h vld=%b cnt=%h, want all 0",
                     bus.Instruction_ID, bus.PCNow_ID, bus.PCNext4_ID, bus.Valid_ID, bus.StallCount);
        end
        nChecks++;
        if (bus.PCWrite !== 1'b0 || bus.Bubble_ID !== 1'b1) begin
            nFails++;
            $display("FAIL reset_ctrl2: PCWrite=%b Bubble=%b, want 0 1", bus.PCWrite, bus.Bubble_ID);
        end
        drive(32'h8C220004, 32'h0000_0040, 1'b0, 5'd0, 1'b0);
        rst = 1'b0;
        #1;
        nChecks++;
        if (bus.PCWrite !== 1'b1 || bus.Bubble_ID !== 1'b0) begin
            nFails++;
            $display("FAIL post_reset_ctrl: PCWrite=%b Bubble=%b, want 1 0", bus.PCWrite, bus.Bubble_ID);
        end
        tick();
        nChecks++;
        if (bus.Instruction_ID !== 32'h8C220004 || bus.Valid_ID !== 1'b1 ||
            bus.PCNow_ID !== 32'h40 || bus.PCNext4_ID !== 32'h44) begin
            nFails++;
            $display("FAIL first_fetch: instr=%h vld=%b pc=%h pc4=%h, want 8c220004 1 40 44",
                     bus.Instruction_ID, bus.Valid_ID, bus.PCNow_ID, bus.PCNext4_ID);
        end
    endtask

    // ID holds add $3,$2,$4 (rs=2, rt=4); a load writing $2 must stall it.
    task automatic test_load_use();
        drive(32'h00441820, 32'h100, 1'b0, 5'd0, 1'b0);
        tick();
        drive(32'hAAAA5555, 32'h104, 1'b1, 5'd2, 1'b0);
        #1;
        nChecks++;
        if (bus.PCWrite !== 1'b0 || bus.Bubble_ID !== 1'b1) begin
            nFails++;
            $display("FAIL loaduse_ctrl: PCWrite=%b Bubble=%b, want 0 1", bus.PCWrite, bus.Bubble_ID);
        end
        tick();
        nChecks++;
        if (bus.Instruction_ID !== 32'h00441820 || bus.PCNow_ID !== 32'h100 ||
            bus.Valid_ID !== 1'b1 || bus.StallCount !== 16'd1 || dut.state !== 2'b01) begin
            nFails++;
            $display("FAIL loaduse_hold: instr=%h pc=%h vld=%b cnt=%0d st=%0d, want 00441820 100 1 1 1",
                     bus.Instruction_ID, bus.PCNow_ID, bus.Valid_ID, bus.StallCount, dut.state);
        end
        drive(32'hAAAA5555, 32'h104, 1'b0, 5'd2, 1'b0);
        #1;
        nChecks++;
        if (bus.PCWrite !== 1'b1 || bus.Bubble_ID !== 1'b0) begin
            nFails++;
            $display("FAIL loaduse_clear: PCWrite=%b Bubble=%b, want 1 0", bus.PCWrite, bus.Bubble_ID);
        end
        tick();
        nChecks++;
        if (bus.Instruction_ID !== 32'hAAAA5555 || bus.PCNow_ID !== 32'h104 ||
            bus.StallCount !== 16'd1 || dut.state !== 2'b00) begin
            nFails++;
            $display("FAIL loaduse_resume: instr=%h pc=%h cnt=%0d st=%0d, want aaaa5555 104 1 0",
                     bus.Instruction_ID, bus.PCNow_ID, bus.StallCount, dut.state);
        end
    endtask

    task automatic test_branch_flush();
        drive(32'h12345678, 32'h200, 1'b0, 5'd0, 1'b1);
        #1;
        nChecks++;
        if (bus.PCWrite !== 1'b1 || bus.Bubble_ID !== 1'b1) begin
            nFails++;
            $display("FAIL branch_ctrl: PCWrite=%b Bubble=%b, want 1 1", bus.PCWrite, bus.Bubble_ID);
        end
        tick();
        nChecks++;
        if (bus.Instruction_ID !== 32'h0 || bus.Valid_ID !== 1'b0 || bus.PCNow_ID !== 32'h0 ||
            dut.state !== 2'b10) begin
            nFails++;
            $display("FAIL branch_flush: instr=%h vld=%b pc=%h st=%0d, want 0 0 0 2",
                     bus.Instruction_ID, bus.Valid_ID, bus.PCNow_ID, dut.state);
        end
        drive(32'h23456789, 32'h300, 1'b0, 5'd0, 1'b1);
        tick();
        nChecks++;
        if (bus.Instruction_ID !== 32'h0 || bus.Valid_ID !== 1'b0 || dut.state !== 2'b10) begin
            nFails++;
            $display("FAIL reflush: instr=%h vld=%b st=%0d, want 0 0 2",
                     bus.Instruction_ID, bus.Valid_ID, dut.state);
        end
        drive(32'h00441820, 32'h400, 1'b1, 5'd0, 1'b0);
        #1;
        nChecks++;
        if (bus.PCWrite !== 1'b1 || bus.Bubble_ID !== 1'b0) begin
            nFails++;
            $display("FAIL flush_exit_ctrl: PCWrite=%b Bubble=%b, want 1 0", bus.PCWrite, bus.Bubble_ID);
        end
        tick();
        nChecks++;
        if (bus.Instruction_ID !== 32'h00441820 || bus.Valid_ID !== 1'b1 ||
            bus.PCNext4_ID !== 32'h404 || dut.state !== 2'b00) begin
            nFails++;
            $display("FAIL flush_exit: instr=%h vld=%b pc4=%h st=%0d, want 00441820 1 404 0",
                     bus.Instruction_ID, bus.Valid_ID, bus.PCNext4_ID, dut.state);
        end
    endtask

    // ID still holds rs=2/rt=4; hazard via rt plus a branch in the same cycle.
    task automatic test_branch_and_hazard();
        drive(32'h11111111, 32'h500, 1'b1, 5'd4, 1'b1);
        #1;
        nChecks++;
        if (bus.PCWrite !== 1'b1 || bus.Bubble_ID !== 1'b1) begin
            nFails++;
            $display("FAIL br_haz_ctrl: PCWrite=%b Bubble=%b, want 1 1", bus.PCWrite, bus.Bubble_ID);
        end
        tick();
        nChecks++;
        if (bus.Instruction_ID !== 32'h0 || bus.Valid_ID !== 1'b0 || bus.StallCount !== 16'd1 ||
            dut.state !== 2'b10) begin
            nFails++;
            $display("FAIL br_haz: instr=%h vld=%b cnt=%0d st=%0d, want 0 0 1 2",
                     bus.Instruction_ID, bus.Valid_ID, bus.StallCount, dut.state);
        end
    endtask

    // add $2,$0,$0 in ID: rs=rt=0, load into $0 must not stall.
    task automatic test_reg_zero();
        drive(32'h00001020, 32'h600, 1'b0, 5'd0, 1'b0);
        tick();
        drive(32'h22222222, 32'h604, 1'b1, 5'd0, 1'b0);
        #1;
        nChecks++;
        if (bus.PCWrite !== 1'b1 || bus.Bubble_ID !== 1'b0) begin
            nFails++;
            $display("FAIL reg0_ctrl: PCWrite=%b Bubble=%b, want 1 0", bus.PCWrite, bus.Bubble_ID);
        end
        tick();
        nChecks++;
        if (bus.Instruction_ID !== 32'h22222222 || bus.StallCount !== 16'd1) begin
            nFails++;
            $display("FAIL reg0_load: instr=%h cnt=%0d, want 22222222 1",
                     bus.Instruction_ID, bus.StallCount);
        end
    endtask

    task automatic test_saturation();
        drive(32'h00441820, 32'h700, 1'b0, 5'd0, 1'b0);
        tick();
        drive(32'h33333333, 32'h704, 1'b1, 5'd2, 1'b0);
        tick();
        tick();
        nChecks++;
        if (bus.StallCount !== 16'd3 || bus.Instruction_ID !== 32'h00441820) begin
            nFails++;
            $display("FAIL stall_repeat: cnt=%0d instr=%h, want 3 00441820",
                     bus.StallCount, bus.Instruction_ID);
        end
        repeat (65538) @(posedge clk);
        #1;
        nChecks++;
        if (bus.StallCount !== 16'hFFFF || bus.PCWrite !== 1'b0) begin
            nFails++;
            $display("FAIL saturate: cnt=%h PCWrite=%b, want ffff 0", bus.StallCount, bus.PCWrite);
        end
        drive(32'h33333333, 32'h704, 1'b1, 5'd2, 1'b1);
        tick();
        nChecks++;
        if (bus.StallCount !== 16'hFFFF || bus.Valid_ID !== 1'b0 || dut.state !== 2'b10) begin
            nFails++;
            $display("FAIL stall_branch: cnt=%h vld=%b st=%0d, want ffff 0 2",
                     bus.StallCount, bus.Valid_ID, dut.state);
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(32'h00441820, 32'h800, 1'b0, 5'd0, 1'b0);
        tick();
        drive(32'h44444444, 32'h804, 1'b1, 5'd2, 1'b0);
        tick();
        nChecks++;
        if (dut.state !== 2'b01) begin
            nFails++;
            $display("FAIL pre_reset_stall: st=%0d, want 1", dut.state);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        nChecks++;
        if (bus.Valid_ID !== 1'b0 || bus.Instruction_ID !== 32'h0 || bus.StallCount !== 16'h0 ||
            dut.state !== 2'b00) begin
            nFails++;
            $display("FAIL reset_mid_stall: vld=%b instr=%h cnt=%h st=%0d, want 0 0 0 0",
                     bus.Valid_ID, bus.Instruction_ID, bus.StallCount, dut.state);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        nChecks++;
        if (bus.PCWrite !== 1'b1 || bus.Bubble_ID !== 1'b0) begin
            nFails++;
            $display("FAIL post_reset_run: PCWrite=%b Bubble=%b, want 1 0", bus.PCWrite, bus.Bubble_ID);
        end
        tick();
        nChecks++;
        if (bus.Instruction_ID !== 32'h44444444 || bus.Valid_ID !== 1'b1) begin
            nFails++;
            $display("FAIL post_reset_load: instr=%h vld=%b, want 44444444 1",
                     bus.Instruction_ID, bus.Valid_ID);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_flush();
        test_branch_and_hazard();
        test_reg_zero();
        test_saturation();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
